// File: rtl/pipeline_if_id_if.sv
// Instruction-memory request/response bundle between the IF/ID stage and imem.
// The master side issues requests; the slave side returns ack and data.
interface pipeline_if_id_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pipeline_if_id.sv
// Fetch completion and IF/ID register: variable-latency imem handshake,
// one-entry stall buffer, in-flight squash on flush, sticky fetch timeout.
module pipeline_if_id #(
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       PC,
  input  logic [31:0]       IF_PC,
  pipeline_if_id_if.master  imem,
  output logic [31:0]       ID_Instruction,
  output logic [31:0]       ID_PC_plus4,
  output logic              ID_valid,
  output logic              fetch_busy,
  output logic              imem_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] req_addr, req_pc4;
  logic [31:0] hold_instr, hold_pc4;
  logic [31:0] cur_pc4;
  logic [7:0]  wait_cnt, wait_cnt_inc;
  logic        got, deliver, waiting, stay_waiting;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (flush)              state_d = FETCH;
        else if (imem.imem_ack) state_d = stall ? HOLD : FETCH;
        else                    state_d = WAIT;
      end
      // An ack coinciding with flush is simply discarded, so no DROP is needed.
      WAIT: begin
        if (imem.imem_ack) state_d = (stall && !flush) ? HOLD : FETCH;
        else               state_d = flush ? DROP : WAIT;
      end
      HOLD: if (flush || !stall) state_d = FETCH;
      DROP: if (imem.imem_ack)   state_d = FETCH;
      default:                   state_d = FETCH;
    endcase
  end

  always_comb begin
    got            = imem.imem_ack && (state_q == FETCH || state_q == WAIT);
    deliver        = !flush && !stall && (got || state_q == HOLD);
    imem.imem_req  = !reset && (state_q != HOLD);
    imem.imem_addr = (state_q == FETCH) ? PC : req_addr;
    cur_pc4        = (state_q == FETCH) ? IF_PC : req_pc4;
    fetch_busy     = !flush && !deliver;
    waiting        = (state_q == WAIT) || (state_q == DROP);
    stay_waiting   = (state_d == WAIT) || (state_d == DROP);
    wait_cnt_inc   = (wait_cnt == '1) ? wait_cnt : wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ID_Instruction <= NOP_INSTR;
      ID_PC_plus4    <= '0;
      ID_valid       <= 1'b0;
      req_addr       <= '0;
      req_pc4        <= '0;
      hold_instr     <= '0;
      hold_pc4       <= '0;
    end else begin
      if (state_q == FETCH) begin
        req_addr <= PC;
        req_pc4  <= IF_PC;
      end
      if (flush) begin
        ID_Instruction <= NOP_INSTR;
        ID_valid       <= 1'b0;
      end else if (stall) begin
        if (got) begin
          hold_instr <= imem.imem_rdata;
          hold_pc4   <= cur_pc4;
        end
      end else if (deliver) begin
        if (state_q == HOLD) begin
          ID_Instruction <= hold_instr;
          ID_PC_plus4    <= hold_pc4;
        end else begin
          ID_Instruction <= imem.imem_rdata;
          ID_PC_plus4    <= cur_pc4;
        end
        ID_valid <= 1'b1;
      end else begin
        ID_Instruction <= NOP_INSTR;
        ID_valid       <= 1'b0;
      end
    end
  end

  // Counter runs only while a request stays unanswered; a response on the
  // final counted cycle therefore does not raise the error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      imem_err <= 1'b0;
    end else if (waiting && stay_waiting) begin
      wait_cnt <= wait_cnt_inc;
      if (wait_cnt_inc == TIMEOUT_CNT) imem_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_if_id.sv
// Directed-vector bench for pipeline_if_id with hand-computed expectations.
module tb_pipeline_if_id;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] PC, IF_PC;
  logic [31:0] ID_Instruction, ID_PC_plus4;
  logic        ID_valid, fetch_busy, imem_err;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] words [3];

  pipeline_if_id_if mem ();

  pipeline_if_id #(.NOP_INSTR(NOP), .TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .PC             (PC),
    .IF_PC          (IF_PC),
    .imem           (mem.master),
    .ID_Instruction (ID_Instruction),
    .ID_PC_plus4    (ID_PC_plus4),
    .ID_valid       (ID_valid),
    .fetch_busy     (fetch_busy),
    .imem_err       (imem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid);
    check({tag, "_instr"}, ID_Instruction, instr);
    check({tag, "_pc4"}, ID_PC_plus4, pc4);
    check({tag, "_valid"}, 32'(ID_valid), 32'(valid));
  endtask

  initial begin
    words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    reset = 1'b1; stall = 1'b0; flush = 1'b0; PC = '0; IF_PC = '0;
    mem.imem_ack = 1'b0; mem.imem_rdata = '0;
    #2;
    check("rst_req", 32'(mem.imem_req), 32'd0);
    check("rst_err", 32'(imem_err), 32'd0);
    check_id("rst", NOP, 32'h0, 1'b0);
    tick(); tick();
    reset = 1'b0;

    // zero-wait memory
    for (int i = 0; i < 3; i++) begin
      PC = 32'h8000_0000 + 32'(4 * i); IF_PC = PC + 32'd4;
      mem.imem_ack = 1'b1; mem.imem_rdata = words[i];
      #1;
      check("zw_req", 32'(mem.imem_req), 32'd1);
      check("zw_addr", mem.imem_addr, PC);
      check("zw_busy", 32'(fetch_busy), 32'd0);
      tick();
      check_id("zw", words[i], 32'h8000_0004 + 32'(4 * i), 1'b1);
    end

    // latency 3
    PC = 32'h8000_0000; IF_PC = 32'h8000_0004; mem.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("l3_busy", 32'(fetch_busy), 32'd1);
      check("l3_addr", mem.imem_addr, 32'h8000_0000);
      tick();
      check("l3_bub_valid", 32'(ID_valid), 32'd0);
      check("l3_bub_instr", ID_Instruction, NOP);
    end
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'hAAAA_0001;
    #1;
    check("l3_ack_busy", 32'(fetch_busy), 32'd0);
    tick();
    check_id("l3", 32'hAAAA_0001, 32'h8000_0004, 1'b1);

    // stall two cycles, ack in the first
    PC = 32'h8000_0010; IF_PC = 32'h8000_0014;
    stall = 1'b1; mem.imem_rdata = 32'hBBBB_0002;
    #1;
    check("st_busy", 32'(fetch_busy), 32'd1);
    tick();
    check_id("st_hold1", 32'hAAAA_0001, 32'h8000_0004, 1'b1);
    mem.imem_ack = 1'b0; mem.imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("st_hold_req", 32'(mem.imem_req), 32'd0);
    tick();
    check_id("st_hold2", 32'hAAAA_0001, 32'h8000_0004, 1'b1);
    stall = 1'b0;
    #1;
    check("st_rel_busy", 32'(fetch_busy), 32'd0);
    check("st_rel_req", 32'(mem.imem_req), 32'd0);
    tick();
    check_id("st_out", 32'hBBBB_0002, 32'h8000_0014, 1'b1);
    PC = 32'h8000_0018; IF_PC = 32'h8000_001C;
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'hCCCC_0003;
    #1;
    check("st_next_req", 32'(mem.imem_req), 32'd1);
    check("st_next_addr", mem.imem_addr, 32'h8000_0018);
    tick();
    check_id("st_next", 32'hCCCC_0003, 32'h8000_001C, 1'b1);

    // flush while waiting, late ack dropped
    PC = 32'h8000_0000; IF_PC = 32'h8000_0004; mem.imem_ack = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("fl_busy", 32'(fetch_busy), 32'd0);
    tick();
    check_id("fl", NOP, 32'h8000_001C, 1'b0);
    flush = 1'b0; PC = 32'h8000_0004; IF_PC = 32'h8000_0008;
    #1;
    check("drop_addr", mem.imem_addr, 32'h8000_0000);
    check("drop_req", 32'(mem.imem_req), 32'd1);
    check("drop_busy", 32'(fetch_busy), 32'd1);
    tick();
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'hBAD0_BAD0;
    #1;
    check("drop_ack_busy", 32'(fetch_busy), 32'd1);
    tick();
    check_id("drop_ack", NOP, 32'h8000_001C, 1'b0);
    mem.imem_rdata = 32'hDDDD_0004;
    #1;
    check("fl_new_addr", mem.imem_addr, 32'h8000_0004);
    tick();
    check_id("fl_new", 32'hDDDD_0004, 32'h8000_0008, 1'b1);

    // flush and ack in the same cycle
    PC = 32'h8000_0020; IF_PC = 32'h8000_0024; mem.imem_ack = 1'b0;
    tick();
    flush = 1'b1; mem.imem_ack = 1'b1; mem.imem_rdata = 32'hBAD1_BAD1;
    tick();
    check_id("fa", NOP, 32'h8000_0008, 1'b0);
    flush = 1'b0; PC = 32'h8000_0040; IF_PC = 32'h8000_0044;
    mem.imem_rdata = 32'hEEEE_0005;
    #1;
    check("fa_next_addr", mem.imem_addr, 32'h8000_0040);
    tick();
    check_id("fa_next", 32'hEEEE_0005, 32'h8000_0044, 1'b1);

    // timeout with TIMEOUT_CYCLES=4
    PC = 32'h8000_0100; IF_PC = 32'h8000_0104; mem.imem_ack = 1'b0;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("to_err", 32'(imem_err), (k >= 4) ? 32'd1 : 32'd0);
    end
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'hFFFF_0006;
    tick();
    check_id("to_resp", 32'hFFFF_0006, 32'h8000_0104, 1'b1);
    check("to_sticky", 32'(imem_err), 32'd1);

    // reset asserted mid-wait
    stall = 1'b1; mem.imem_ack = 1'b0; PC = 32'h8000_0200; IF_PC = 32'h8000_0204;
    tick();
    #2 reset = 1'b1;
    #1;
    check("ar_req", 32'(mem.imem_req), 32'd0);
    check("ar_err", 32'(imem_err), 32'd0);
    check_id("ar", NOP, 32'h0, 1'b0);
    tick();
    reset = 1'b0; stall = 1'b0; PC = 32'h8000_0300; IF_PC = 32'h8000_0304;
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'h1234_5678;
    #1;
    check("post_rst_addr", mem.imem_addr, 32'h8000_0300);
    tick();
    check_id("post_rst", 32'h1234_5678, 32'h8000_0304, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
